ocp2axi_cpl: RTL
================

// Module: ocp2axi_cpl
// PURPOSE
// Return path of the PCIe-to-OCP bridge. Collects OCP read responses (SResp/SData) for a pending
// memory read, builds a PCIe 3DW Completion TLP, and writes it into the AXI-stream TX FIFO.
// A CplD carries the data. A Cpl with no data carries error status. The RX translator supplies
// the per-request context (requester ID, tag, lower address, length).
// PARAMETERS
// FIFO_W   64   AXI-stream tdata width; fixed, 2 DW per beat
// DATA_W   32   OCP SData width; one DW per response
// PORTS
// clk              in   1   clock
// reset            in   1   reset, synchronous, active-high
// cpl_req_valid    in   1   completion context valid
// cpl_req_ready    out  1   context accepted when valid&ready
// cpl_req_id       in   16  requester ID
// cpl_tag          in   8   request tag
// cpl_lower_addr   in   7   lower address of request
// cpl_length       in   10  length in DW; 0 means 1024
// completer_id     in   16  this function's ID; static
// ocp_sresp        in   2   00 NULL, 01 DVA, 10 FAIL, 11 ERR
// ocp_sdata        in   32  response data
// ocp_mrespaccept  out  1   response consumed when sresp!=NULL & mrespaccept
// s_axis_tvalid    out  1   TX FIFO beat valid
// s_axis_tready    in   1   TX FIFO ready
// s_axis_tdata     out  64  beat data; TLP byte n at bits [8n+7:8n]; earlier DW in [31:0]
// s_axis_tkeep     out  8   byte enables; FF, or 0F on a half last beat
// s_axis_tlast     out  1   last beat of TLP
// resp_err         out  1   1-cycle pulse on ERR/FAIL response after the first
// BEHAVIOUR
// - Reset values: every output is 0. State is IDLE. Any partial TLP is abandoned without tlast.
//   The TX FIFO is reset together with this block.
// - All outputs are registered. AXI rule: while tvalid & !tready, tdata/tkeep/tlast stay stable.
// - len = (cpl_length==0) ? 1024 : cpl_length, held in an 11-bit register. rem counts DWs still owed.
// - States:
//   - IDLE: cpl_req_ready=1. On handshake, latch the context, set rem=len, go to FIRST.
//   - FIRST: mrespaccept=1. Wait for a non-NULL response, latch data and status, rem-1.
//     DVA: status=000, fmt=010 (CplD), go to HDR0.
//     ERR: status=100 (CA), fmt=000, length field 0, go to HDR0.
//     FAIL: status=001 (UR), fmt=000, length field 0, go to HDR0.
//   - HDR0: beat = {DW1,DW0}, tkeep FF. On tready, go to HDR1.
//     DW0: [7:0]={fmt,5'b01010}, [15:8]=0, [23:16]={6'b0,len[9:8]}, [31:24]=len[7:0].
//     DW1: [15:0]={cid[7:0],cid[15:8]}, [23:16]={status,1'b0,bc[11:8]}, [31:24]=bc[7:0].
//     bc = len*4 mod 4096, so 1024 DW encodes 0.
//   - HDR1: DW2 = {1'b0,lower_addr, tag, rid[7:0], rid[15:8]} in bits [31:0].
//     CplD: the first data DW goes in [63:32], tkeep FF, tlast=(rem==0).
//     Cpl: tkeep 0F, tlast=1.
//     On tready: rem==0 → IDLE; Cpl with rem>0 → DRAIN; otherwise → GATHER.
//   - GATHER: mrespaccept=1 only while no beat is pending. Accepted DWs pack low then high.
//     A full pair, or a single DW with rem reaching 0, loads the beat and goes to SEND.
//     A single-DW last beat has tkeep 0F with data in [31:0].
//   - SEND: tvalid held until tready. Then GATHER if rem>0, else IDLE with tlast set on that beat.
//   - DRAIN: mrespaccept=1. Discard rem responses, then IDLE.
// - NULL sresp never counts. ERR/FAIL after the first response is forwarded as data and pulses
//   resp_err; the completion status is not changed.
// - Beats per CplD = ceil((3+len)/2). The last beat has tkeep 0F when len is even.
// - cpl_req_ready is 0 outside IDLE. Only one completion is in flight at a time.
// - Reset mid-operation: next cycle every output is 0 and state is IDLE.
// TESTING
// - len=1, rid=0x0100, tag=0x05, la=0x04, cid=0x0200, DVA 0xDEADBEEF. Expect 2 beats:
//   64'h04000002_0100004A, then 64'hDEADBEEF_04050001 with tkeep FF and tlast.
// - len=4, DVA D0..D3. Expect 4 beats: hdr0 (bc=16), {D0,DW2}, {D2,D1}, {0,D3} with tkeep 0F
//   and tlast. cpl_req_ready returns 1 the cycle after.
// - cpl_length=0 (1024 DW). Expect DW0 length 0, bc field 0, 514 beats, last beat tkeep 0F.
// - len=4, first sresp=ERR. Expect Cpl DW0=32'h0000000A, status 100, beat1 tkeep 0F with tlast.
//   Then 3 more responses accepted, nothing emitted, back to IDLE.
// - len=8, random tready stalls plus NULL gaps on sresp. Expect tdata stable while stalled and
//   all 8 DWs in order. mrespaccept=0 whenever a beat is pending.
// - Reset asserted in GATHER of a len=8 read. Expect all outputs 0 next cycle, no tlast, and the
//   next request completes correctly.

Source files
------------

// File: rtl/ocp2axi_cpl_if.sv
// ocp2axi_cpl_if: context, OCP response and AXI-stream TX signals of the completion builder
interface ocp2axi_cpl_if;
  logic        cpl_req_valid;
  logic        cpl_req_ready;
  logic [15:0] cpl_req_id;
  logic [7:0]  cpl_tag;
  logic [6:0]  cpl_lower_addr;
  logic [9:0]  cpl_length;
  logic [15:0] completer_id;
  logic [1:0]  ocp_sresp;
  logic [31:0] ocp_sdata;
  logic        ocp_mrespaccept;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        resp_err;
  modport slave (
    input  cpl_req_valid, cpl_req_id, cpl_tag, cpl_lower_addr, cpl_length, completer_id,
    input  ocp_sresp, ocp_sdata, s_axis_tready,
    output cpl_req_ready, ocp_mrespaccept, s_axis_tvalid, s_axis_tdata, s_axis_tkeep,
    output s_axis_tlast, resp_err
  );
  modport master (
    output cpl_req_valid, cpl_req_id, cpl_tag, cpl_lower_addr, cpl_length, completer_id,
    output ocp_sresp, ocp_sdata, s_axis_tready,
    input  cpl_req_ready, ocp_mrespaccept, s_axis_tvalid, s_axis_tdata, s_axis_tkeep,
    input  s_axis_tlast, resp_err
  );
endinterface

// File: rtl/ocp2axi_cpl.sv
// ocp2axi_cpl: turns OCP read responses into a 3DW PCIe Cpl/CplD TLP on the 64-bit AXI-stream TX FIFO
module ocp2axi_cpl (
  input logic clk,
  input logic reset,
  ocp2axi_cpl_if.slave bus
);
  localparam int FIFO_W = 64;
  localparam int DATA_W = 32;
  typedef enum logic [2:0] {IDLE, FIRST, HDR0, HDR1, GATHER, SEND, DRAIN} state_t;
  state_t              state_q;
  logic [15:0]         rid_q;
  logic [7:0]          tag_q;
  logic [6:0]          la_q;
  logic [10:0]         len_q, rem_q;
  logic                cpl_q, have_lo_q;
  logic [DATA_W-1:0]   dw_q, lo_q;
  logic                req_ready_q, accept_q, tvalid_q, tlast_q, resp_err_q;
  logic [FIFO_W-1:0]   tdata_q;
  logic [7:0]          tkeep_q;
  logic [10:0]         req_len;
  logic                resp_v, beat_done, rsp_cpl;
  logic [2:0]          rsp_status;
  logic [9:0]          len_field;
  logic [11:0]         bc;
  logic [31:0]         hdr_dw0, hdr_dw1, hdr_dw2;
  // header fields depend on the first response's status, so they are built while it is being accepted
  always_comb begin
    req_len    = bus.cpl_length == 10'd0 ? 11'd1024 : {1'b0, bus.cpl_length};
    resp_v     = bus.ocp_sresp != 2'b00 && accept_q;
    beat_done  = tvalid_q && bus.s_axis_tready;
    rsp_cpl    = bus.ocp_sresp != 2'b01;
    rsp_status = bus.ocp_sresp == 2'b01 ? 3'b000 : bus.ocp_sresp == 2'b11 ? 3'b100 : 3'b001;
    len_field  = (rsp_cpl || len_q[10]) ? 10'd0 : len_q[9:0];
    bc         = len_q[10] ? 12'd0 : {len_q[9:0], 2'b00};
    hdr_dw0    = {len_field[7:0], 6'b0, len_field[9:8], 8'h00, rsp_cpl ? 3'b000 : 3'b010, 5'b01010};
    hdr_dw1    = {bc[7:0], rsp_status, 1'b0, bc[11:8], bus.completer_id[7:0], bus.completer_id[15:8]};
    hdr_dw2    = {1'b0, la_q, tag_q, rid_q[7:0], rid_q[15:8]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rid_q       <= '0;
      tag_q       <= '0;
      la_q        <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      cpl_q       <= 1'b0;
      have_lo_q   <= 1'b0;
      dw_q        <= '0;
      lo_q        <= '0;
      req_ready_q <= 1'b0;
      accept_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      resp_err_q  <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
    end else begin
      resp_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.cpl_req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            rid_q       <= bus.cpl_req_id;
            tag_q       <= bus.cpl_tag;
            la_q        <= bus.cpl_lower_addr;
            len_q       <= req_len;
            rem_q       <= req_len;
            accept_q    <= 1'b1;
            state_q     <= FIRST;
          end
        end
        FIRST: if (resp_v) begin
          dw_q     <= bus.ocp_sdata;
          cpl_q    <= rsp_cpl;
          rem_q    <= rem_q - 11'd1;
          accept_q <= 1'b0;
          tvalid_q <= 1'b1;
          tdata_q  <= {hdr_dw1, hdr_dw0};
          tkeep_q  <= 8'hFF;
          tlast_q  <= 1'b0;
          state_q  <= HDR0;
        end
        HDR0: if (beat_done) begin
          tdata_q <= {cpl_q ? 32'h0 : dw_q, hdr_dw2};
          tkeep_q <= cpl_q ? 8'h0F : 8'hFF;
          tlast_q <= cpl_q || rem_q == 11'd0;
          state_q <= HDR1;
        end
        HDR1: if (beat_done) begin
          tvalid_q  <= 1'b0;
          tlast_q   <= 1'b0;
          have_lo_q <= 1'b0;
          if (rem_q == 11'd0) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            accept_q <= 1'b1;
            state_q  <= cpl_q ? DRAIN : GATHER;
          end
        end
        GATHER: if (resp_v) begin
          rem_q      <= rem_q - 11'd1;
          resp_err_q <= bus.ocp_sresp[1];
          if (have_lo_q || rem_q == 11'd1) begin
            tdata_q   <= have_lo_q ? {bus.ocp_sdata, lo_q} : {32'h0, bus.ocp_sdata};
            tkeep_q   <= have_lo_q ? 8'hFF : 8'h0F;
            tlast_q   <= rem_q == 11'd1;
            tvalid_q  <= 1'b1;
            accept_q  <= 1'b0;
            have_lo_q <= 1'b0;
            state_q   <= SEND;
          end else begin
            lo_q      <= bus.ocp_sdata;
            have_lo_q <= 1'b1;
          end
        end
        SEND: if (beat_done) begin
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          if (rem_q == 11'd0) begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            accept_q <= 1'b1;
            state_q  <= GATHER;
          end
        end
        DRAIN: if (resp_v) begin
          rem_q      <= rem_q - 11'd1;
          resp_err_q <= bus.ocp_sresp[1];
          if (rem_q == 11'd1) begin
            accept_q    <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.cpl_req_ready   = req_ready_q;
  assign bus.ocp_mrespaccept = accept_q;
  assign bus.s_axis_tvalid   = tvalid_q;
  assign bus.s_axis_tdata    = tdata_q;
  assign bus.s_axis_tkeep    = tkeep_q;
  assign bus.s_axis_tlast    = tlast_q;
  assign bus.resp_err        = resp_err_q;
endmodule
